// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: decides when a pending interrupt is taken and drives
// the forced-CALL entry (push, vector load, flush/NOP cycles); also edge-detects the INT pin.
module interrupt_sequencer #(
  parameter logic [12:0] VECTOR_ADDR  = 13'h0004,
  parameter int unsigned DUMMY_CYCLES = 4,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  intcon_val,
  input  logic [7:0]  pir1_val,
  input  logic [7:0]  pie1_val,
  input  logic        instr_boundary,
  input  logic        retfie_exec,
  input  logic [12:0] pc_next,
  input  logic        int_pin,
  input  logic        intedg,
  output logic        intf_set,
  output logic        gie_clr,
  output logic        gie_set,
  output logic        stack_push,
  output logic [12:0] stack_push_addr,
  output logic        pc_vec_en,
  output logic [12:0] pc_vec_addr,
  output logic        instr_flush_req,
  output logic        busy
);

  localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int unsigned DW     = (DUMMY_CYCLES > 1) ? $clog2(DUMMY_CYCLES) : 1;
  localparam int unsigned SW     = $clog2(SYNC_N + 2);
  localparam logic [DW-1:0] DUMMY_LAST = DW'((DUMMY_CYCLES > 0) ? DUMMY_CYCLES - 1 : 0);
  localparam logic [SW-1:0] SUP_INIT   = SW'(SYNC_N + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_PUSH,
    S_LOAD,
    S_DUMMY
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic            gie_set_q, gie_set_d;
  logic [SYNC_N-1:0] sync_q, sync_d;
  logic            hist_q, hist_d;
  logic [SW-1:0]   sup_q, sup_d;
  logic            intf_set_q, intf_set_d;
  logic            pending;
  logic            edge_hit;

  always_comb begin
    pending = intcon_val[7] &
              ((intcon_val[5] & intcon_val[2]) |
               (intcon_val[4] & intcon_val[1]) |
               (intcon_val[3] & intcon_val[0]) |
               (intcon_val[6] & (|(pie1_val & pir1_val))));
  end

  // Entry FSM; pending is only considered in IDLE/ARMED so a sequence can never nest.
  always_comb begin
    state_d         = state_q;
    dcnt_d          = dcnt_q;
    stack_push      = 1'b0;
    stack_push_addr = '0;
    gie_clr         = 1'b0;
    pc_vec_en       = 1'b0;
    instr_flush_req = 1'b0;
    busy            = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pending && instr_boundary) state_d = S_PUSH;
        else if (pending)              state_d = S_ARMED;
      end
      S_ARMED: begin
        if (!pending)            state_d = S_IDLE;
        else if (instr_boundary) state_d = S_PUSH;
      end
      S_PUSH: begin
        stack_push      = 1'b1;
        stack_push_addr = pc_next;
        gie_clr         = 1'b1;
        instr_flush_req = 1'b1;
        busy            = 1'b1;
        state_d         = S_LOAD;
      end
      S_LOAD: begin
        pc_vec_en       = 1'b1;
        instr_flush_req = 1'b1;
        busy            = 1'b1;
        dcnt_d          = DUMMY_LAST;
        state_d         = (DUMMY_CYCLES == 0) ? S_IDLE : S_DUMMY;
      end
      S_DUMMY: begin
        instr_flush_req = 1'b1;
        busy            = 1'b1;
        if (dcnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          dcnt_d = dcnt_q - DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gie_set_d = retfie_exec;
  end

  // INT pin: synchroniser, history flop and edge detect, masked until the chain
  // has filled with real pin samples after reset release.
  always_comb begin
    sync_d     = {sync_q[SYNC_N-2:0], int_pin};
    hist_d     = sync_q[SYNC_N-1];
    edge_hit   = intedg ? (sync_q[SYNC_N-1] & ~hist_q) : (~sync_q[SYNC_N-1] & hist_q);
    sup_d      = (sup_q != '0) ? sup_q - SW'(1) : sup_q;
    intf_set_d = edge_hit & (sup_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dcnt_q     <= '0;
      gie_set_q  <= 1'b0;
      sync_q     <= '0;
      hist_q     <= 1'b0;
      sup_q      <= SUP_INIT;
      intf_set_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
      gie_set_q  <= gie_set_d;
      sync_q     <= sync_d;
      hist_q     <= hist_d;
      sup_q      <= sup_d;
      intf_set_q <= intf_set_d;
    end
  end

  assign gie_set     = gie_set_q;
  assign intf_set    = intf_set_q;
  assign pc_vec_addr = VECTOR_ADDR;

endmodule
